// File: rtl/logic_capture_pkg.sv
// Shared definitions for the capture engine: trigger modes, FSM states and
// register bit positions.
package logic_capture_pkg;

    localparam logic [1:0] MODE_LEVEL  = 2'd0;
    localparam logic [1:0] MODE_EDGE   = 2'd1;
    localparam logic [1:0] MODE_CHANGE = 2'd2;
    localparam logic [1:0] MODE_IMM    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_t;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_TRIG      = 1;
    localparam int STAT_DONE      = 2;
    localparam int STAT_ADDR_LSB  = 16;

    localparam int CTRL_ARM       = 0;
    localparam int CTRL_ABORT     = 1;

    localparam int CFG0_VALUE_LSB = 0;
    localparam int CFG0_MASK_LSB  = 16;
    localparam int CFG1_PRE_LSB   = 0;
    localparam int CFG1_MODE_LSB  = 16;

endpackage

// File: rtl/logic_trigger_eval.sv
// Combinational trigger decision for one sample against the latched
// value/mask and the previously written sample.
module logic_trigger_eval
    import logic_capture_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] s,
    input  logic [DATA_W-1:0] s_prev,
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] mask,
    input  logic [1:0]        mode,
    input  logic              prev_valid,
    output logic              trig
);

    logic match;
    logic prev_match;
    logic change;

    // Match/edge/change terms and mode selection
    always_comb begin
        match      = (((s ^ value) & mask) == '0);
        prev_match = (((s_prev ^ value) & mask) == '0);
        change     = (((s ^ s_prev) & mask) != '0);
        trig       = 1'b0;
        case (mode)
            MODE_LEVEL:  trig = match;
            MODE_EDGE:   trig = match & ~prev_match & prev_valid;
            MODE_CHANGE: trig = change & prev_valid;
            MODE_IMM:    trig = 1'b1;
            default:     trig = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_capture_pt.sv
// Circular-buffer capture engine with pre-trigger window, masked triggering,
// abort and trigger-address reporting. The FSM state decides the next write;
// RAM outputs and status flags are registered one cycle behind that decision.
module logic_capture_pt
    import logic_capture_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    output logic [31:0]       status,
    input  logic [31:0]       control,
    input  logic [31:0]       config0,
    input  logic [31:0]       config1,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              we,
    output logic              en,
    output logic [ADDR_W-1:0] address
);

    localparam logic [16:0] DEPTH_M1 = 17'((32'd1 << ADDR_W) - 32'd1);

    state_t              state;
    logic [DATA_W-1:0]   sample_p0;
    logic [DATA_W-1:0]   sample_prev_p1;
    logic [DATA_W-1:0]   value_lat;
    logic [DATA_W-1:0]   mask_lat;
    logic [1:0]          mode_lat;
    logic [ADDR_W-1:0]   p_lat;
    logic [ADDR_W-1:0]   post_lat;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   trig_addr;
    logic                arm_prev;
    logic                prev_valid;
    logic                trig_pend_p1;
    logic                triggered;
    logic                done;
    logic                trig;
    logic                busy;
    logic                arm_rise;
    logic                abort;
    logic [16:0]         p_req_ext;
    logic [ADDR_W-1:0]   p_clamp;
    logic                unused_cfg;

    assign arm_rise  = control[CTRL_ARM] & ~arm_prev;
    assign abort     = control[CTRL_ABORT];
    assign p_req_ext = {1'b0, config1[CFG1_PRE_LSB +: 16]};
    assign p_clamp   = (p_req_ext > DEPTH_M1) ? DEPTH_M1[ADDR_W-1:0] : p_req_ext[ADDR_W-1:0];
    assign busy      = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST) || we;
    assign en        = we;
    assign unused_cfg = ^{control, config0, config1};

    logic_trigger_eval #(.DATA_W(DATA_W)) u_trig (
        .s          (sample_p0),
        .s_prev     (sample_prev_p1),
        .value      (value_lat),
        .mask       (mask_lat),
        .mode       (mode_lat),
        .prev_valid (prev_valid),
        .trig       (trig)
    );

    // Input register: probe bus sampled every cycle
    always_ff @(posedge clk) begin
        sample_p0 <= datain;
    end

    // Capture FSM, write port, counters and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            we           <= 1'b0;
            dataout      <= '0;
            address      <= '0;
            wr_ptr       <= '0;
            cnt          <= '0;
            trig_addr    <= '0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            trig_pend_p1 <= 1'b0;
            arm_prev     <= 1'b1;
            prev_valid   <= 1'b0;
            p_lat        <= '0;
            post_lat     <= '0;
            value_lat    <= '0;
            mask_lat     <= '0;
            mode_lat     <= MODE_LEVEL;
        end else begin
            arm_prev     <= control[CTRL_ARM];
            trig_pend_p1 <= 1'b0;
            // The trigger sample's write cycle ends here: publish its address
            if (trig_pend_p1) begin
                triggered <= 1'b1;
                trig_addr <= address;
            end
            if (abort) begin
                state     <= ST_IDLE;
                we        <= 1'b0;
                triggered <= 1'b0;
                done      <= 1'b0;
                trig_addr <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        we <= 1'b0;
                        if (state == ST_DONE) done <= 1'b1;
                        // A write still in flight counts as busy, so arm waits for it
                        if (arm_rise && !we) begin
                            triggered  <= 1'b0;
                            done       <= 1'b0;
                            wr_ptr     <= '0;
                            cnt        <= '0;
                            prev_valid <= 1'b0;
                            value_lat  <= config0[CFG0_VALUE_LSB +: DATA_W];
                            mask_lat   <= config0[CFG0_MASK_LSB +: DATA_W];
                            mode_lat   <= config1[CFG1_MODE_LSB +: 2];
                            p_lat      <= p_clamp;
                            post_lat   <= ~p_clamp;
                            state      <= (p_clamp != '0) ? ST_PRE : ST_ARMED;
                        end
                    end
                    ST_PRE, ST_ARMED, ST_POST: begin
                        we             <= 1'b1;
                        dataout        <= sample_p0;
                        address        <= wr_ptr;
                        wr_ptr         <= wr_ptr + ADDR_W'(1);
                        sample_prev_p1 <= sample_p0;
                        prev_valid     <= 1'b1;
                        cnt            <= cnt + ADDR_W'(1);
                        if (state == ST_PRE) begin
                            if (cnt == p_lat - ADDR_W'(1)) state <= ST_ARMED;
                        end else if (state == ST_ARMED) begin
                            if (trig) begin
                                trig_pend_p1 <= 1'b1;
                                cnt          <= '0;
                                state        <= (post_lat == '0) ? ST_DONE : ST_POST;
                            end
                        end else begin
                            if (cnt == post_lat - ADDR_W'(1)) state <= ST_DONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        we    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Status register image
    always_comb begin
        status                      = '0;
        status[STAT_BUSY]           = busy;
        status[STAT_TRIG]           = triggered;
        status[STAT_DONE]           = done;
        status[STAT_ADDR_LSB +: 16] = 16'(trig_addr);
    end

endmodule

// File: tb/tb_logic_capture_pt.sv
// Directed bench for logic_capture_pt (DATA_W=8, ADDR_W=4): expected RAM
// writes are queued when a capture is started and popped as writes appear.
module tb_logic_capture_pt;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] status;
    logic [31:0] control;
    logic [31:0] config0;
    logic [31:0] config1;
    logic [7:0]  datain;
    logic [7:0]  dataout;
    logic        we;
    logic        en;
    logic [3:0]  address;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] samp[64];
    int         total_n = 0;
    int         bad_n   = 0;

    always #5 clk = ~clk;

    logic_capture_pt #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .status  (status),
        .control (control),
        .config0 (config0),
        .config1 (config1),
        .datain  (datain),
        .dataout (dataout),
        .we      (we),
        .en      (en),
        .address (address)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_n++;
        assert (obs === expv) else begin
            bad_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; afterwards every RAM write is matched against the queue
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(address), 32'(e.addr));
                check("wr_data", 32'(dataout), 32'(e.data));
                check("wr_en", 32'(en), 32'd1);
            end
        end
    endtask

    task automatic capture(input string tag, input int preq, input logic [1:0] mode,
                           input logic [7:0] val, input logic [7:0] msk, input int tidx);
        int eff_p;
        int total;
        bit seen_trig;
        bit fin;
        eff_p = (preq > 15) ? 15 : preq;
        total = tidx + 1 + (15 - eff_p);
        config0 = {8'h00, msk, 8'h00, val};
        config1 = {14'h0, mode, 16'(preq)};
        control = 32'h0;
        datain  = 8'h00;
        tick();
        exp_q.delete();
        for (int k = 0; k < total; k++) exp_q.push_back('{addr: 4'(k % 16), data: samp[k % 64]});
        control = 32'h1;
        datain  = samp[0];
        tick();
        check({tag, "_arm_we"}, 32'(we), 32'd0);
        check({tag, "_arm_busy"}, 32'(status[0]), 32'd1);
        check({tag, "_arm_flags"}, 32'(status[2:1]), 32'd0);
        seen_trig = 1'b0;
        fin       = 1'b0;
        for (int j = 1; j < 200 && !fin; j++) begin
            datain = samp[j % 64];
            tick();
            if (!seen_trig && status[1] === 1'b1) begin
                seen_trig = 1'b1;
                check({tag, "_trig_cycle"}, 32'(j), 32'(tidx + 2));
                check({tag, "_trig_addr"}, 32'(status[31:16]), 32'(tidx % 16));
            end
            if (status[2] === 1'b1) begin
                fin = 1'b1;
                check({tag, "_done_cycle"}, 32'(j), 32'(total + 1));
                check({tag, "_done_trig"}, 32'(status[1]), 32'd1);
                check({tag, "_done_we"}, 32'(we), 32'd0);
                check({tag, "_done_busy"}, 32'(status[0]), 32'd0);
                check({tag, "_left_writes"}, 32'(exp_q.size()), 32'd0);
            end
        end
        if (!fin) begin
            check({tag, "_timeout"}, 32'(status[2]), 32'd1);
            exp_q.delete();
        end
        control = 32'h0;
    endtask

    initial begin
        // Reset with arm held high
        reset   = 1'b1;
        control = 32'h1;
        config0 = 32'h0;
        config1 = 32'h0;
        datain  = 8'h00;
        tick();
        tick();
        check("rst_status", status, 32'h0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_dataout", 32'(dataout), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("armheld_status", status, 32'h0);
        check("armheld_we", 32'(we), 32'd0);
        control = 32'h0;

        // Level trigger, P=4: 0x7B is the 10th written sample
        for (int j = 0; j < 64; j++) samp[j] = 8'(8'h72 + j);
        capture("lvl", 4, 2'd0, 8'h7B, 8'hFF, 9);

        // Edge trigger, P=0: first 0x01 has no predecessor
        for (int j = 0; j < 64; j++) samp[j] = 8'(j * 3);
        samp[0] = 8'h01;
        samp[1] = 8'h00;
        samp[2] = 8'h03;
        capture("edge", 0, 2'd1, 8'h01, 8'h01, 2);

        // Wrap with P request clamped to 15, trigger on the 40th sample
        for (int j = 0; j < 64; j++) samp[j] = 8'(j);
        samp[39] = 8'hAA;
        capture("wrap", 100, 2'd0, 8'hAA, 8'hFF, 39);

        // Abort during ARMED
        for (int j = 0; j < 64; j++) samp[j] = 8'(j);
        config0 = 32'h00FF_00FF;
        config1 = 32'h0000_0002;
        control = 32'h0;
        datain  = 8'h00;
        tick();
        exp_q.delete();
        for (int k = 0; k < 5; k++) exp_q.push_back('{addr: 4'(k), data: samp[k]});
        control = 32'h1;
        datain  = samp[0];
        tick();
        for (int j = 1; j <= 5; j++) begin
            datain = samp[j];
            tick();
        end
        check("abort_pre_busy", 32'(status[0]), 32'd1);
        control = 32'h3;
        tick();
        check("abort_we", 32'(we), 32'd0);
        check("abort_status", status, 32'h0);
        check("abort_writes", 32'(exp_q.size()), 32'd0);
        control = 32'h0;
        tick();
        check("abort_idle_we", 32'(we), 32'd0);
        check("abort_idle_status", status, 32'h0);

        // Re-arm after abort: immediate mode, P=3
        for (int j = 0; j < 64; j++) samp[j] = 8'(8'hC0 + j);
        capture("imm", 3, 2'd3, 8'h00, 8'h00, 3);

        // Masked change: bit 7 change ignored, bit 2 change triggers
        for (int j = 0; j < 64; j++) samp[j] = 8'(8'h94 + j);
        samp[0] = 8'h10;
        samp[1] = 8'h90;
        samp[2] = 8'h94;
        capture("chg", 0, 2'd2, 8'h00, 8'h0F, 2);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
